// File: rtl/ldst_pkg.sv
// Shared encodings for the load/store sequencer: op codes, FSM states and the
// packed command word carried through the command FIFO.
package ldst_pkg;

    localparam int ADDR_W = 2;
    localparam int CMD_W  = 5;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_MOVE  = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_EXEC    = 2'b01;
    localparam logic [1:0] ST_MOVE_WR = 2'b10;

    typedef struct packed {
        logic [1:0]        op;
        logic              sel;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

    // MOVE reads first; its write half is produced by the MOVE_WR state.
    function automatic logic isRead(input logic [1:0] op);
        return (op == OP_LOAD) || (op == OP_MOVE);
    endfunction

    function automatic logic isWrite(input logic [1:0] op);
        return (op == OP_STORE);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with extra-bit pointers; pushes while full and
// pops while empty are dropped. DEPTH must be a power of two, at least 2.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             CLK,
    input  logic             Rst,
    input  logic             pushEn,
    input  logic [WIDTH-1:0] pushData,
    input  logic             popEn,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wrPtr;
    logic [PTR_W:0]   rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty   = (wrPtr == rdPtr);
    assign full    = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                     (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
    assign doPush  = pushEn && !full;
    assign doPop   = popEn && !empty;
    assign popData = mem[rdPtr[PTR_W-1:0]];

    always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    // Storage needs no reset: emptiness is defined purely by the pointers.
    always_ff @(posedge CLK) begin
        if (doPush) mem[wrPtr[PTR_W-1:0]] <= pushData;
    end

endmodule

// File: rtl/ldst_seq.sv
// Load/store sequencer: queues commands and issues registered RE/WE strobes,
// splitting MOVE into a read at Addr followed by a write at Addr+1.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | nothing in flight, strobes low
//   ST_EXEC    | command strobes active (final cycle unless MOVE)
//   ST_MOVE_WR | write half of a MOVE, final cycle of the MOVE
module ldst_seq
    import ldst_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        Rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        cmd_sel,
    input  logic [1:0]  cmd_addr,
    output logic        Sel,
    output logic        RE,
    output logic        WE,
    output logic [1:0]  Addr,
    output logic        done,
    output logic        busy,
    output logic [7:0]  issued_cnt
);

    logic [1:0]       state;
    logic [1:0]       curOp;
    logic [CMD_W-1:0] headRaw;
    cmd_t             head;
    logic             full;
    logic             empty;
    logic             popEn;

    assign head      = cmd_t'(headRaw);
    assign cmd_ready = !full;
    assign busy      = (state != ST_IDLE) || !empty;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .CLK      (CLK),
        .Rst      (Rst),
        .pushEn   (cmd_valid),
        .pushData ({cmd_op, cmd_sel, cmd_addr}),
        .popEn    (popEn),
        .popData  (headRaw),
        .full     (full),
        .empty    (empty)
    );

    always_comb begin
        popEn = 1'b0;
        case (state)
            ST_IDLE:    popEn = !empty;
            ST_EXEC:    popEn = !empty && (curOp != OP_MOVE);
            ST_MOVE_WR: popEn = !empty;
            default:    popEn = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
            state      <= ST_IDLE;
            curOp      <= OP_NOP;
            Sel        <= 1'b0;
            Addr       <= '0;
            RE         <= 1'b0;
            WE         <= 1'b0;
            done       <= 1'b0;
            issued_cnt <= '0;
        end else begin
            RE   <= 1'b0;
            WE   <= 1'b0;
            done <= 1'b0;
            if (state == ST_EXEC && curOp == OP_MOVE) begin
                state      <= ST_MOVE_WR;
                WE         <= 1'b1;
                Addr       <= Addr + 2'd1;
                done       <= 1'b1;
                issued_cnt <= issued_cnt + 8'd1;
            end else if (popEn) begin
                state <= ST_EXEC;
                curOp <= head.op;
                Sel   <= head.sel;
                Addr  <= head.addr;
                RE    <= isRead(head.op);
                WE    <= isWrite(head.op);
                // MOVE completes (and counts) in its write half instead.
                done  <= (head.op != OP_MOVE);
                if (head.op == OP_LOAD || head.op == OP_STORE)
                    issued_cnt <= issued_cnt + 8'd1;
            end else begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ldst_seq.sv
// Scoreboard bench for ldst_seq: expected strobe cycles are queued when a
// command is accepted and compared as the sequencer issues them.
module tb_ldst_seq;
    import ldst_pkg::*;

    logic       CLK = 1'b0;
    logic       Rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic       cmd_sel = 1'b0;
    logic [1:0] cmd_addr = 2'b00;
    logic       Sel, RE, WE, done, busy;
    logic [1:0] Addr;
    logic [7:0] issued_cnt;

    typedef struct packed {
        logic       re;
        logic       we;
        logic       sel;
        logic [1:0] addr;
        logic       done;
        logic       counts;
    } exp_t;

    exp_t       expQ[$];
    exp_t       monE;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] expCnt = 8'd0;
    bit         sawFull = 1'b0;

    ldst_seq #(.FIFO_DEPTH(4)) dut (
        .CLK        (CLK),
        .Rst        (Rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_sel    (cmd_sel),
        .cmd_addr   (cmd_addr),
        .Sel        (Sel),
        .RE         (RE),
        .WE         (WE),
        .Addr       (Addr),
        .done       (done),
        .busy       (busy),
        .issued_cnt (issued_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic sendCmd(input logic [1:0] op, input logic sel, input logic [1:0] addr);
        int         waitCyc;
        logic [1:0] nxt;
        waitCyc   = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_sel   = sel;
        cmd_addr  = addr;
        while (!cmd_ready && waitCyc < 200) begin
            sawFull = 1'b1;
            @(negedge CLK);
            waitCyc++;
        end
        if (!cmd_ready) begin
            check("acceptTimeout", {31'd0, cmd_ready}, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        nxt = addr + 2'd1;
        case (op)
            OP_LOAD:  expQ.push_back('{1'b1, 1'b0, sel, addr, 1'b1, 1'b1});
            OP_STORE: expQ.push_back('{1'b0, 1'b1, sel, addr, 1'b1, 1'b1});
            OP_MOVE: begin
                expQ.push_back('{1'b1, 1'b0, sel, addr, 1'b0, 1'b0});
                expQ.push_back('{1'b0, 1'b1, sel, nxt, 1'b1, 1'b1});
            end
            default:  expQ.push_back('{1'b0, 1'b0, sel, addr, 1'b1, 1'b0});
        endcase
        @(negedge CLK);
        cmd_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((busy || expQ.size() != 0) && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        check("drainQueue", expQ.size(), 0);
        check("drainBusy", {31'd0, busy}, 32'd0);
    endtask

    always @(negedge CLK) begin
        if (Rst) begin
            check("reWeExclusive", {31'd0, RE & WE}, 32'd0);
            if (RE || WE || done) begin
                if (expQ.size() == 0) begin
                    check("spuriousStrobe", {29'd0, RE, WE, done}, 32'd0);
                end else begin
                    monE = expQ.pop_front();
                    check("strobe", {26'd0, RE, WE, Sel, Addr, done},
                          {26'd0, monE.re, monE.we, monE.sel, monE.addr, monE.done});
                    if (monE.counts) expCnt = expCnt + 8'd1;
                    if (monE.done) check("issuedCnt", {24'd0, issued_cnt}, {24'd0, expCnt});
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2 Rst = 1'b0;
        repeat (3) @(negedge CLK);
        check("rstReady", {31'd0, cmd_ready}, 32'd1);
        check("rstBusy", {31'd0, busy}, 32'd0);
        check("rstOutputs", {26'd0, Sel, RE, WE, Addr, done}, 32'd0);
        check("rstCnt", {24'd0, issued_cnt}, 32'd0);
        Rst = 1'b1;
        @(negedge CLK);

        // Single LOAD: one cycle of latency through the FIFO, no bypass.
        sendCmd(OP_LOAD, 1'b1, 2'd2);
        check("noBypass", {31'd0, RE}, 32'd0);
        check("busyQueued", {31'd0, busy}, 32'd1);
        waitDrain();
        check("cntAfterLoad", {24'd0, issued_cnt}, 32'd1);

        // MOVE at the top address wraps its write to address 0.
        sendCmd(OP_MOVE, 1'b0, 2'd3);
        waitDrain();
        check("cntAfterMove", {24'd0, issued_cnt}, 32'd2);

        // MOVEs slow the drain so the following STOREs fill the FIFO.
        sawFull = 1'b0;
        for (int i = 0; i < 4; i++) sendCmd(OP_MOVE, i[0], i[1:0]);
        for (int i = 0; i < 5; i++) sendCmd(OP_STORE, ~i[0], i[1:0]);
        check("sawFull", {31'd0, sawFull}, 32'd1);
        waitDrain();

        // Reset during a MOVE write half with three commands still queued.
        for (int i = 0; i < 5; i++) sendCmd(OP_MOVE, 1'b1, i[1:0]);
        n = 0;
        while (!WE && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("reachedMoveWr", {31'd0, WE}, 32'd1);
        #1 Rst = 1'b0;
        expQ.delete();
        expCnt = 8'd0;
        #1;
        check("midRstStrobes", {26'd0, Sel, RE, WE, Addr, done}, 32'd0);
        check("midRstReady", {31'd0, cmd_ready}, 32'd1);
        check("midRstBusy", {31'd0, busy}, 32'd0);
        check("midRstCnt", {24'd0, issued_cnt}, 32'd0);
        @(negedge CLK);
        Rst = 1'b1;
        repeat (20) @(negedge CLK);
        check("postRstBusy", {31'd0, busy}, 32'd0);
        check("postRstCnt", {24'd0, issued_cnt}, 32'd0);

        // 256 LOADs bring the 8-bit counter back to 0.
        for (int i = 0; i < 256; i++)
            sendCmd(OP_LOAD, 1'($urandom_range(1)), 2'($urandom_range(3)));
        waitDrain();
        check("cntWrap", {24'd0, issued_cnt}, 32'd0);

        sendCmd(OP_NOP, 1'b1, 2'd1);
        waitDrain();
        check("nopCnt", {24'd0, issued_cnt}, 32'd0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) @(negedge CLK);
            sendCmd(2'($urandom_range(3)), 1'($urandom_range(1)), 2'($urandom_range(3)));
        end
        waitDrain();
        check("randCnt", {24'd0, issued_cnt}, {24'd0, expCnt});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
